// File: rtl/rr_sel_arb_if.sv
// rtl/rr_sel_arb_if.sv - request/operand/result bundle for the round-robin selector
interface rr_sel_arb_if #(
  parameter int N = 2
);
  logic [3:0]   req;
  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic [N-1:0] opc;
  logic [N-1:0] opd;
  logic         out_ready;
  logic [3:0]   req_ack;
  logic [1:0]   sel;
  logic [N-1:0] result;
  logic         out_valid;

  modport master (
    output req, opa, opb, opc, opd, out_ready,
    input  req_ack, sel, result, out_valid
  );

  modport slave (
    input  req, opa, opb, opc, opd, out_ready,
    output req_ack, sel, result, out_valid
  );
endinterface

// File: rtl/rr_sel_arb.sv
// rtl/rr_sel_arb.sv - four-channel round-robin arbiter with registered sel/result output
// Optional RR_SEL_PRIO0_EN: channel 0 wins whenever it requests.
module rr_sel_arb #(
  parameter int N = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_sel_arb_if.slave bus
);
  logic [1:0]   ptr_q;
  logic [1:0]   sel_q;
  logic [N-1:0] result_q;
  logic         out_valid_q;

  logic         ld;
  logic [3:0]   req_m;
  logic [1:0]   grant;
  logic         gnt_vld;
  logic [N-1:0] op_grant;

  assign ld = !out_valid_q || bus.out_ready;

  always_comb begin
    req_m = bus.req;
`ifdef RR_SEL_PRIO0_EN
    // Collapsing the request vector to channel 0 lets the rotating search grant it unconditionally.
    if (bus.req[0]) begin
      req_m = 4'b0001;
    end
`endif
  end

  // Walk offsets from the far end so the closest requester to ptr is the last one written.
  always_comb begin
    logic [1:0] idx;
    grant   = ptr_q;
    gnt_vld = 1'b0;
    idx     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + i[1:0];
      if (req_m[idx]) begin
        grant   = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    op_grant = bus.opa;
    case (grant)
      2'd0:    op_grant = bus.opa;
      2'd1:    op_grant = bus.opb;
      2'd2:    op_grant = bus.opc;
      default: op_grant = bus.opd;
    endcase
  end

  assign bus.req_ack = (rst_n && ld && gnt_vld) ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      sel_q       <= 2'd0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (ld) begin
      if (gnt_vld) begin
        result_q    <= op_grant;
        sel_q       <= grant;
        out_valid_q <= 1'b1;
        ptr_q       <= grant + 2'd1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_sel_arb.sv
// tb/tb_rr_sel_arb.sv - self-checking bench for rr_sel_arb with a behavioural arbitration model
module tb_rr_sel_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  rr_sel_arb_if #(.N(2)) bus ();

  rr_sel_arb #(.N(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_valid;
  int m_sel;
  int m_res;
  int m_ptr;
  int ops[4] = '{0, 1, 2, 3};
  bit prio0;
  int last_ack;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_sel   = 0;
    m_res   = 0;
    m_ptr   = 0;
  endtask

  // Channel that must win: channel 0 first when prioritised, else first requester from ptr onward.
  function automatic int pick(input logic [3:0] r);
    if (prio0 && r[0]) return 0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [3:0] r, input logic rdy);
    int g;
    int ld;
    int exp_ack;
    bus.req       = r;
    bus.out_ready = rdy;
    @(negedge clk);
    ld      = (m_valid == 0 || rdy) ? 1 : 0;
    g       = pick(r);
    exp_ack = (rst_n && ld != 0 && g >= 0) ? (1 << g) : 0;
    last_ack = int'(bus.req_ack);
    check("req_ack",   int'(bus.req_ack),   exp_ack);
    check("out_valid", int'(bus.out_valid), m_valid);
    check("sel",       int'(bus.sel),       m_sel);
    check("result",    int'(bus.result),    m_res);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (ld != 0) begin
      if (g >= 0) begin
        m_res   = ops[g];
        m_sel   = g;
        m_valid = 1;
        m_ptr   = (g + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    int exp;
    prio0 = 1'b0;
`ifdef RR_SEL_PRIO0_EN
    prio0 = 1'b1;
`endif
    bus.opa       = 2'd0;
    bus.opb       = 2'd1;
    bus.opc       = 2'd2;
    bus.opd       = 2'd3;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;

    // Reset held with all channels requesting
    repeat (3) cycle(4'b1111, 1'b1);
    check("rst_valid",  int'(bus.out_valid), 0);
    check("rst_sel",    int'(bus.sel),       0);
    check("rst_result", int'(bus.result),    0);
    check("rst_ack",    last_ack,            0);
    rst_n = 1'b1;

    // Full load: rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1);
      exp = prio0 ? 0 : i % 4;
      check("full_ack",    last_ack,            1 << exp);
      check("full_sel",    int'(bus.sel),       exp);
      check("full_result", int'(bus.result),    exp);
      check("full_valid",  int'(bus.out_valid), 1);
    end

    // Single channel held
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 1'b1);
      check("single_ack",    last_ack,            4);
      check("single_sel",    int'(bus.sel),       2);
      check("single_result", int'(bus.result),    2);
      check("single_valid",  int'(bus.out_valid), 1);
    end

    // Backpressure: advance until channel 1 is held, then stall
    for (int k = 0; k < 8 && bus.sel != 2'd1; k++) cycle(4'b1110, 1'b1);
    check("bp_reach_sel1", int'(bus.sel), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1110, 1'b0);
      check("bp_hold_ack",    last_ack,            0);
      check("bp_hold_sel",    int'(bus.sel),       1);
      check("bp_hold_result", int'(bus.result),    1);
      check("bp_hold_valid",  int'(bus.out_valid), 1);
    end
    cycle(4'b1110, 1'b1);
    check("bp_resume_ack", last_ack,      4);
    check("bp_resume_sel", int'(bus.sel), 2);
    cycle(4'b0000, 1'b1);
    check("drain_valid",  int'(bus.out_valid), 0);
    check("drain_sel",    int'(bus.sel),       2);
    check("drain_result", int'(bus.result),    2);
    cycle(4'b0000, 1'b1);
    check("idle_valid", int'(bus.out_valid), 0);

    // Mid-operation asynchronous reset while channel 3 is held
    cycle(4'b1110, 1'b1);
    check("pre_rst_sel",   int'(bus.sel),       3);
    check("pre_rst_valid", int'(bus.out_valid), 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid",  int'(bus.out_valid), 0);
    check("async_rst_sel",    int'(bus.sel),       0);
    check("async_rst_result", int'(bus.result),    0);
    check("async_rst_ack",    int'(bus.req_ack),   0);
    cycle(4'b1010, 1'b1);
    rst_n = 1'b1;
    cycle(4'b1010, 1'b1);
    check("rst_seq_sel0", int'(bus.sel), 1);
    cycle(4'b1010, 1'b1);
    check("rst_seq_sel1", int'(bus.sel), 3);
    cycle(4'b1010, 1'b1);
    check("rst_seq_sel2", int'(bus.sel), 1);

`ifdef RR_SEL_PRIO0_EN
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b1);
      check("prio_sel0", int'(bus.sel), 0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1110, 1'b1);
      check("prio_rot_sel", int'(bus.sel), i + 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
